// File: rtl/vx_hw_itr_ctrl_pkg.sv
// Shared definitions for the per-core hardware interrupt controller:
// CSR address window, register offsets, delivery FSM states and request record.
package vx_hw_itr_ctrl_pkg;

    localparam int CSR_ADDR_BITS = 12;

    localparam logic [CSR_ADDR_BITS-1:0] HW_ITR_CTRL_BEGIN = 12'hBC0;
    localparam logic [CSR_ADDR_BITS-1:0] HW_ITR_CTRL_END   = HW_ITR_CTRL_BEGIN + 12'd6;

    localparam int ITR_OFF_IE     = 0;
    localparam int ITR_OFF_IP     = 1;
    localparam int ITR_OFF_CAUSE  = 2;
    localparam int ITR_OFF_VECTOR = 3;
    localparam int ITR_OFF_RET    = 4;
    localparam int ITR_OFF_SWI    = 5;

    localparam logic [CSR_ADDR_BITS-1:0] ITR_ADDR_IE     = HW_ITR_CTRL_BEGIN + 12'(ITR_OFF_IE);
    localparam logic [CSR_ADDR_BITS-1:0] ITR_ADDR_IP     = HW_ITR_CTRL_BEGIN + 12'(ITR_OFF_IP);
    localparam logic [CSR_ADDR_BITS-1:0] ITR_ADDR_CAUSE  = HW_ITR_CTRL_BEGIN + 12'(ITR_OFF_CAUSE);
    localparam logic [CSR_ADDR_BITS-1:0] ITR_ADDR_VECTOR = HW_ITR_CTRL_BEGIN + 12'(ITR_OFF_VECTOR);
    localparam logic [CSR_ADDR_BITS-1:0] ITR_ADDR_RET    = HW_ITR_CTRL_BEGIN + 12'(ITR_OFF_RET);
    localparam logic [CSR_ADDR_BITS-1:0] ITR_ADDR_SWI    = HW_ITR_CTRL_BEGIN + 12'(ITR_OFF_SWI);

    // Request record sized for the largest supported configuration.
    localparam int ITR_MAX_WID_W = 8;
    localparam int ITR_MAX_SRC_W = 5;

    typedef struct packed {
        logic [ITR_MAX_WID_W-1:0] wid;
        logic [ITR_MAX_SRC_W-1:0] cause;
        logic [31:0]              vector;
    } itr_req_t;

    typedef enum logic {
        ITR_IDLE,
        ITR_REQ
    } itr_state_t;

    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_hw_itr_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module vx_hw_itr_ctrl_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         valid
);

    int unsigned slot;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        slot  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            slot = (32'(ptr) + i) % N;
            if (!valid && req[slot]) begin
                valid       = 1'b1;
                grant[slot] = 1'b1;
                idx         = W'(slot);
            end
        end
    end

endmodule

// File: rtl/vx_hw_itr_ctrl.sv
// Per-core hardware interrupt controller: per-warp IE/IP/CAUSE/in_handler state,
// CSR access, round-robin selection and one-at-a-time valid/ready delivery.
module vx_hw_itr_ctrl
    import vx_hw_itr_ctrl_pkg::*;
#(
    parameter int CORE_ID   = 0,
    parameter int WARP_CNT  = 4,
    parameter int NUM_LANES = 4,
    parameter int NUM_SRCS  = 8,
    parameter int WID_W     = log2up(WARP_CNT),
    localparam int SRC_W    = log2up(NUM_SRCS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      csr_read_enable,
    input  logic [WID_W-1:0]          csr_read_wid,
    input  logic [CSR_ADDR_BITS-1:0]  csr_read_addr,
    output logic [NUM_LANES*32-1:0]   csr_read_data,
    input  logic                      csr_write_enable,
    input  logic [WID_W-1:0]          csr_write_wid,
    input  logic [CSR_ADDR_BITS-1:0]  csr_write_addr,
    input  logic [NUM_LANES*32-1:0]   csr_write_data,
    input  logic                      irq_valid,
    input  logic [WID_W-1:0]          irq_wid,
    input  logic [SRC_W-1:0]          irq_src,
    output logic                      itr_valid,
    output logic [WID_W-1:0]          itr_wid,
    output logic [SRC_W-1:0]          itr_cause,
    output logic [31:0]               itr_vector,
    input  logic                      itr_ready,
    output logic [WARP_CNT-1:0]       in_handler
);

    logic [NUM_SRCS-1:0] ie      [WARP_CNT];
    logic [NUM_SRCS-1:0] ip      [WARP_CNT];
    logic [NUM_SRCS-1:0] ip_n    [WARP_CNT];
    logic [SRC_W-1:0]    cause_q [WARP_CNT];
    logic [31:0]         vector_q;
    logic [WARP_CNT-1:0] handler_q;
    logic [WID_W-1:0]    rr_ptr;
    itr_state_t          state, state_n;
    itr_req_t            req_q;

    logic [WARP_CNT-1:0] elig, grant;
    logic [WID_W-1:0]    arb_idx;
    logic                arb_valid;
    logic [NUM_SRCS-1:0] pend_sel;
    logic [SRC_W-1:0]    cause_sel;
    logic                load, handshake;
    logic [WID_W-1:0]    req_wid;
    logic [SRC_W-1:0]    req_cause;
    logic [NUM_SRCS-1:0] wdata;
    logic                wr_ie, wr_ip, wr_vector, wr_ret, wr_swi;
    logic [31:0]         rd_word;

    assign req_wid   = req_q.wid[WID_W-1:0];
    assign req_cause = req_q.cause[SRC_W-1:0];
    assign wdata     = csr_write_data[NUM_SRCS-1:0];

    assign wr_ie     = csr_write_enable && (csr_write_addr == ITR_ADDR_IE);
    assign wr_ip     = csr_write_enable && (csr_write_addr == ITR_ADDR_IP);
    assign wr_vector = csr_write_enable && (csr_write_addr == ITR_ADDR_VECTOR);
    assign wr_ret    = csr_write_enable && (csr_write_addr == ITR_ADDR_RET);
    assign wr_swi    = csr_write_enable && (csr_write_addr == ITR_ADDR_SWI);

    always_comb begin
        for (int unsigned w = 0; w < WARP_CNT; w++) begin
            elig[w] = (|(ip[w] & ie[w])) && !handler_q[w];
        end
    end

    vx_hw_itr_ctrl_rr_arbiter #(
        .N (WARP_CNT),
        .W (WID_W)
    ) rr_arbiter (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Lowest enabled pending source of the granted warp.
    always_comb begin
        pend_sel  = '0;
        cause_sel = '0;
        for (int unsigned w = 0; w < WARP_CNT; w++) begin
            if (grant[w]) pend_sel = pend_sel | (ip[w] & ie[w]);
        end
        for (int unsigned s = NUM_SRCS; s > 0; s--) begin
            if (pend_sel[s-1]) cause_sel = SRC_W'(s - 1);
        end
    end

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        handshake = 1'b0;
        case (state)
            ITR_IDLE: begin
                if (arb_valid) begin
                    load    = 1'b1;
                    state_n = ITR_REQ;
                end
            end
            ITR_REQ: begin
                if (itr_ready) begin
                    handshake = 1'b1;
                    state_n   = ITR_IDLE;
                end
            end
            default: state_n = ITR_IDLE;
        endcase
    end

    // Priority within a cycle: CSR clear, then SWI set, then delivery clear, then event set.
    always_comb begin
        for (int unsigned w = 0; w < WARP_CNT; w++) begin
            ip_n[w] = ip[w];
            if (wr_ip && csr_write_wid == WID_W'(w)) ip_n[w] = ip_n[w] & ~wdata;
            if (wr_swi && csr_write_wid == WID_W'(w)) ip_n[w] = ip_n[w] | wdata;
            if (handshake && req_wid == WID_W'(w)) ip_n[w][req_cause] = 1'b0;
            if (irq_valid && irq_wid == WID_W'(w)) ip_n[w][irq_src] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ITR_IDLE;
            req_q    <= '0;
            rr_ptr   <= '0;
            vector_q <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                req_q.wid    <= ITR_MAX_WID_W'(arb_idx);
                req_q.cause  <= ITR_MAX_SRC_W'(cause_sel);
                req_q.vector <= vector_q;
            end
            if (handshake) begin
                rr_ptr <= (req_wid == WID_W'(WARP_CNT - 1)) ? '0 : req_wid + 1'b1;
            end
            if (wr_vector) vector_q <= {csr_write_data[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie        <= '{default: '0};
            ip        <= '{default: '0};
            cause_q   <= '{default: '0};
            handler_q <= '0;
        end else begin
            ip <= ip_n;
            for (int unsigned w = 0; w < WARP_CNT; w++) begin
                if (wr_ie && csr_write_wid == WID_W'(w)) ie[w] <= wdata;
                if (handshake && req_wid == WID_W'(w)) begin
                    cause_q[w]   <= req_cause;
                    handler_q[w] <= 1'b1;
                end else if (wr_ret && csr_write_wid == WID_W'(w)) begin
                    handler_q[w] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (csr_read_enable) begin
            case (csr_read_addr)
                ITR_ADDR_IE:     rd_word = 32'(ie[csr_read_wid]);
                ITR_ADDR_IP:     rd_word = 32'(ip[csr_read_wid]);
                ITR_ADDR_CAUSE:  rd_word = 32'(cause_q[csr_read_wid]);
                ITR_ADDR_VECTOR: rd_word = vector_q;
                default:         rd_word = '0;
            endcase
        end
    end

    assign csr_read_data = {NUM_LANES{rd_word}};
    assign itr_valid     = (state == ITR_REQ);
    assign itr_wid       = req_wid;
    assign itr_cause     = req_cause;
    assign itr_vector    = req_q.vector;
    assign in_handler    = handler_q;

endmodule

// File: tb/tb_vx_hw_itr_ctrl.sv
// Self-checking bench for vx_hw_itr_ctrl: CSR table vectors, delivery scoreboard
// and hand-written sequences for reset, masking, RET and round-robin ordering.
module tb_vx_hw_itr_ctrl;
    import vx_hw_itr_ctrl_pkg::*;

    localparam int WARP_CNT  = 4;
    localparam int NUM_LANES = 4;
    localparam int NUM_SRCS  = 8;
    localparam int WID_W     = 2;
    localparam int SRC_W     = 3;
    localparam int DW        = NUM_LANES * 32;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     csr_read_enable = 1'b0;
    logic [WID_W-1:0]         csr_read_wid = '0;
    logic [CSR_ADDR_BITS-1:0] csr_read_addr = '0;
    logic [DW-1:0]            csr_read_data;
    logic                     csr_write_enable = 1'b0;
    logic [WID_W-1:0]         csr_write_wid = '0;
    logic [CSR_ADDR_BITS-1:0] csr_write_addr = '0;
    logic [DW-1:0]            csr_write_data = '0;
    logic                     irq_valid = 1'b0;
    logic [WID_W-1:0]         irq_wid = '0;
    logic [SRC_W-1:0]         irq_src = '0;
    logic                     itr_valid;
    logic [WID_W-1:0]         itr_wid;
    logic [SRC_W-1:0]         itr_cause;
    logic [31:0]              itr_vector;
    logic                     itr_ready = 1'b0;
    logic [WARP_CNT-1:0]      in_handler;

    vx_hw_itr_ctrl #(
        .CORE_ID   (0),
        .WARP_CNT  (WARP_CNT),
        .NUM_LANES (NUM_LANES),
        .NUM_SRCS  (NUM_SRCS),
        .WID_W     (WID_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .csr_read_enable  (csr_read_enable),
        .csr_read_wid     (csr_read_wid),
        .csr_read_addr    (csr_read_addr),
        .csr_read_data    (csr_read_data),
        .csr_write_enable (csr_write_enable),
        .csr_write_wid    (csr_write_wid),
        .csr_write_addr   (csr_write_addr),
        .csr_write_data   (csr_write_data),
        .irq_valid        (irq_valid),
        .irq_wid          (irq_wid),
        .irq_src          (irq_src),
        .itr_valid        (itr_valid),
        .itr_wid          (itr_wid),
        .itr_cause        (itr_cause),
        .itr_vector       (itr_vector),
        .itr_ready        (itr_ready),
        .in_handler       (in_handler)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          wid;
        int          cause;
        logic [31:0] vector;
    } exp_t;

    typedef struct {
        int          off;
        int          wid;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    int   hs_cyc[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CSR_ADDR_BITS-1:0] addr_of(input int off);
        return HW_ITR_CTRL_BEGIN + 12'(off);
    endfunction

    always @(posedge clk) cyc++;

    // Delivery monitor: a handshake is visible on the falling edge before it commits.
    always @(negedge clk) begin
        if (reset && itr_valid && itr_ready) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_delivery: got wid %0d cause %0d expected none", itr_wid, itr_cause);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dlv_wid", DW'(itr_wid), DW'(e.wid));
                check("dlv_cause", DW'(itr_cause), DW'(e.cause));
                check("dlv_vector", DW'(itr_vector), DW'(e.vector));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input int off, input int wid, input logic [31:0] data);
        csr_write_enable = 1'b1;
        csr_write_addr   = addr_of(off);
        csr_write_wid    = WID_W'(wid);
        csr_write_data   = {{(NUM_LANES-1){32'hDEAD_BEEF}}, data};
        tick();
        csr_write_enable = 1'b0;
        csr_write_data   = '0;
    endtask

    task automatic csr_rd(input int off, input int wid, input bit en, output logic [DW-1:0] d);
        csr_read_enable = en;
        csr_read_addr   = addr_of(off);
        csr_read_wid    = WID_W'(wid);
        #1;
        d = csr_read_data;
        csr_read_enable = 1'b0;
    endtask

    task automatic irq(input int wid, input int src);
        irq_valid = 1'b1;
        irq_wid   = WID_W'(wid);
        irq_src   = SRC_W'(src);
        tick();
        irq_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        itr_ready = 1'b0;
        irq_valid = 1'b0;
        csr_write_enable = 1'b0;
        sb.delete();
        hs_cyc.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d outstanding expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        vec_t        tbl[10];
        logic [DW-1:0] d;
        exp_t        e;

        tbl[0] = '{ITR_OFF_IE,     1, 1'b1, 32'h0000_01FF, 32'h0000_00FF};
        tbl[1] = '{ITR_OFF_IE,     0, 1'b0, 32'h0,         32'h0};
        tbl[2] = '{ITR_OFF_VECTOR, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        tbl[3] = '{ITR_OFF_VECTOR, 3, 1'b0, 32'h0,         32'hFFFF_FFFC};
        tbl[4] = '{ITR_OFF_CAUSE,  1, 1'b1, 32'h0000_0005, 32'h0};
        tbl[5] = '{ITR_OFF_RET,    1, 1'b1, 32'h1234_5678, 32'h0};
        tbl[6] = '{ITR_OFF_SWI,    1, 1'b0, 32'h0,         32'h0};
        tbl[7] = '{6,              1, 1'b1, 32'h0000_00FF, 32'h0};
        tbl[8] = '{ITR_OFF_IE,     3, 1'b1, 32'h0000_003C, 32'h0000_003C};
        tbl[9] = '{ITR_OFF_IE,     1, 1'b0, 32'h0,         32'h0000_00FF};

        // Reset state
        reset = 1'b0;
        #1;
        check("rst_valid", DW'(itr_valid), '0);
        check("rst_wid", DW'(itr_wid), '0);
        check("rst_vector", DW'(itr_vector), '0);
        check("rst_in_handler", DW'(in_handler), '0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) csr_wr(tbl[i].off, tbl[i].wid, tbl[i].wdata);
            csr_rd(tbl[i].off, tbl[i].wid, 1'b1, d);
            check($sformatf("tbl%0d", i), d, {NUM_LANES{tbl[i].exp}});
        end
        check("tbl_no_delivery", DW'(itr_valid), '0);

        // 1: reset while a request is outstanding
        do_reset();
        csr_wr(ITR_OFF_IE, 1, 32'h01);
        irq(1, 0);
        tick();
        check("t1_valid_before_reset", DW'(itr_valid), DW'(1));
        reset = 1'b0;
        #1;
        check("t1_valid_async_clear", DW'(itr_valid), '0);
        check("t1_wid_async_clear", DW'(itr_wid), '0);
        tick();
        reset = 1'b1;
        tick();
        csr_rd(ITR_OFF_IP, 1, 1'b1, d);
        check("t1_ip_after_reset", d, '0);
        check("t1_in_handler_after_reset", DW'(in_handler), '0);

        // 2: single delivery and its commit effects
        do_reset();
        csr_wr(ITR_OFF_IE, 2, 32'h05);
        csr_wr(ITR_OFF_VECTOR, 0, 32'h8000_0103);
        e = '{2, 2, 32'h8000_0100};
        sb.push_back(e);
        irq(2, 2);
        check("t2_valid_t0", DW'(itr_valid), '0);
        tick();
        check("t2_valid_t1", DW'(itr_valid), DW'(1));
        check("t2_wid", DW'(itr_wid), DW'(2));
        check("t2_cause", DW'(itr_cause), DW'(2));
        check("t2_vector", DW'(itr_vector), DW'(32'h8000_0100));
        tick();
        check("t2_held_valid", DW'(itr_valid), DW'(1));
        check("t2_held_cause", DW'(itr_cause), DW'(2));
        itr_ready = 1'b1;
        tick();
        itr_ready = 1'b0;
        check("t2_sb_empty", DW'(sb.size()), '0);
        check("t2_valid_after_hs", DW'(itr_valid), '0);
        csr_rd(ITR_OFF_CAUSE, 2, 1'b1, d);
        check("t2_cause_csr", d, {NUM_LANES{32'd2}});
        csr_rd(ITR_OFF_IP, 2, 1'b1, d);
        check("t2_ip_csr", d, '0);
        check("t2_in_handler", DW'(in_handler), DW'(4'b0100));

        // 3: masked while in handler, released by RET
        irq(2, 0);
        tick();
        tick();
        check("t3_no_valid", DW'(itr_valid), '0);
        csr_rd(ITR_OFF_IP, 2, 1'b1, d);
        check("t3_ip_pending", d, {NUM_LANES{32'h01}});
        e = '{2, 0, 32'h8000_0100};
        sb.push_back(e);
        csr_wr(ITR_OFF_RET, 2, 32'h0);
        check("t3_ret_clears", DW'(in_handler), '0);
        check("t3_valid_r0", DW'(itr_valid), '0);
        tick();
        check("t3_valid_r1", DW'(itr_valid), DW'(1));
        check("t3_cause", DW'(itr_cause), '0);
        itr_ready = 1'b1;
        tick();
        itr_ready = 1'b0;
        check("t3_sb_empty", DW'(sb.size()), '0);

        // 4: round-robin order and back-to-back spacing
        do_reset();
        for (int w = 0; w < WARP_CNT; w++) csr_wr(ITR_OFF_IE, w, 32'hFF);
        for (int w = 0; w < WARP_CNT; w++) begin
            e = '{w, 7, 32'h0};
            sb.push_back(e);
            csr_wr(ITR_OFF_SWI, w, 32'h80);
        end
        itr_ready = 1'b1;
        drain("t4");
        itr_ready = 1'b0;
        check("t4_in_handler_all", DW'(in_handler), DW'(4'b1111));
        check("t4_hs_count", DW'(hs_cyc.size()), DW'(4));
        for (int i = 1; i < 4 && i < hs_cyc.size(); i++) begin
            check($sformatf("t4_spacing%0d", i), DW'(hs_cyc[i] - hs_cyc[i-1]), DW'(2));
        end
        for (int w = 0; w < WARP_CNT; w++) csr_wr(ITR_OFF_RET, w, 32'h0);
        e = '{0, 7, 32'h0};
        sb.push_back(e);
        e = '{2, 7, 32'h0};
        sb.push_back(e);
        irq_valid = 1'b1;
        irq_wid   = 2'd2;
        irq_src   = 3'd7;
        csr_wr(ITR_OFF_SWI, 0, 32'h80);
        irq_valid = 1'b0;
        itr_ready = 1'b1;
        drain("t4_wrap");
        itr_ready = 1'b0;

        // 5: event set beats same-cycle W1C; unmapped and disabled reads
        do_reset();
        csr_wr(ITR_OFF_SWI, 1, 32'h08);
        irq_valid = 1'b1;
        irq_wid   = 2'd1;
        irq_src   = 3'd3;
        csr_wr(ITR_OFF_IP, 1, 32'h08);
        irq_valid = 1'b0;
        csr_rd(ITR_OFF_IP, 1, 1'b1, d);
        check("t5_set_wins", d, {NUM_LANES{32'h08}});
        csr_wr(ITR_OFF_IP, 1, 32'h08);
        csr_rd(ITR_OFF_IP, 1, 1'b1, d);
        check("t5_w1c", d, '0);
        csr_wr(ITR_OFF_IE, 1, 32'h03);
        csr_rd(ITR_OFF_IE, 1, 1'b0, d);
        check("t5_read_disabled", d, '0);
        csr_rd(ITR_OFF_IE, 1, 1'b1, d);
        check("t5_read_enabled", d, {NUM_LANES{32'h03}});
        csr_rd(7, 1, 1'b1, d);
        check("t5_unmapped", d, '0);
        check("t5_no_delivery", DW'(itr_valid), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_hw_itr_ctrl.md
Name: VX_hw_itr_ctrl

Overview:
- Per-core hardware interrupt controller; the target of the CSR unit's hardware-interrupt CSR bus (addresses `VX_HW_ITR_CTRL_BEGIN`..`END`).
- Holds per-warp enable, pending, cause and in-handler state.
- Latches source events and arbitrates round-robin among eligible warps.
- Delivers one interrupt at a time to the warp scheduler over a valid/ready handshake.

Parameters:
- CORE_ID, 0, core index (unused except debug).
- WARP_CNT, 4, warps per core.
- NUM_LANES, 4, lanes of CSR read/write data.
- NUM_SRCS, 8, interrupt sources per warp (≤32).
- WID_W, `LOG2UP(WARP_CNT)`, warp-id width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- csr_read_enable  in  1  CSR read strobe.
- csr_read_wid  in  WID_W  warp issuing the read.
- csr_read_addr  in  `VX_CSR_ADDR_BITS`  CSR address.
- csr_read_data  out  NUM_LANES*32  read value, replicated on all lanes, combinational.
- csr_write_enable  in  1  CSR write strobe.
- csr_write_wid  in  WID_W  warp issuing the write.
- csr_write_addr  in  `VX_CSR_ADDR_BITS`  CSR address.
- csr_write_data  in  NUM_LANES*32  write value; lane 0 used.
- irq_valid  in  1  source event pulse.
- irq_wid  in  WID_W  target warp of the event.
- irq_src  in  `LOG2UP(NUM_SRCS)`  source index.
- itr_valid  out  1  interrupt delivery request.
- itr_wid  out  WID_W  warp to interrupt.
- itr_cause  out  `LOG2UP(NUM_SRCS)`  source being delivered.
- itr_vector  out  32  handler PC.
- itr_ready  in  1  scheduler accepts the delivery.
- in_handler  out  WARP_CNT  per-warp handler-active flags.

Behaviour:

Reset:
- On reset low, all state clears asynchronously, including an in-flight REQ.
- IE, IP, CAUSE, VECTOR, in_handler, and the round-robin pointer go to 0.
- itr_valid, itr_wid, itr_cause and itr_vector all go to 0.
- The FSM returns to IDLE.

CSR map (offset from BEGIN; END = BEGIN+6):
- 0 IE: per-warp RW, NUM_SRCS bits.
- 1 IP: per-warp; read returns pending; write clears the bits set in data (write-1-to-clear).
- 2 CAUSE: per-warp RO; source index of the last delivery.
- 3 VECTOR: global RW, 32 bits; bits [1:0] are forced to 0.
- 4 RET: write of any value clears in_handler[write_wid]; reads 0.
- 5 SWI: write sets the IP bits given in data (software interrupt); reads 0.

CSR read and write timing:
- Reads are combinational from current registers (same cycle), zero-extended to 32 bits.
- Reads return 0 when read_enable is low or the address is unmapped.
- Writes take effect at the next clock edge; unmapped writes are ignored.
- Write data above NUM_SRCS bits is ignored.

Event capture:
- An irq_valid cycle sets IP[irq_wid][irq_src] at the next edge.
- If the same bit is also being cleared by CSR or by a delivery in that cycle, the set wins.
- An event whose bit is already set is merged (no counting).

Eligibility:
- elig[w] = |(IP[w] & IE[w]) && !in_handler[w].

Delivery FSM, IDLE -> REQ -> IDLE:
- IDLE: if any elig, select the first eligible warp at or after rr_ptr (wrapping modulo WARP_CNT).
- On that select, register wid, cause and VECTOR into the itr_* outputs, set itr_valid=1, and enter REQ.
  - cause = lowest-index set bit of IP&IE.
  - Latency: eligibility at edge t gives itr_valid high after edge t+1.
- REQ: outputs are held stable until itr_ready.
- On the itr_ready handshake edge:
  - clear IP[wid][cause];
  - set CAUSE[wid] = cause and in_handler[wid] = 1;
  - set rr_ptr = wid+1 (wrapping);
  - set itr_valid=0 and go to IDLE.
- At most one delivery every 2 cycles.
- A request in REQ is committed: later CSR clears of IE or IP do not retract it.
  - At handshake IP is cleared regardless.
  - in_handler is set regardless.
- A RET write for the warp in REQ during the handshake cycle: the handshake's set of in_handler wins.
- itr_ready while itr_valid=0 is ignored.

Decomposition:
- Shared package VX_gpu_pkg receives:
  - the address offset constants;
  - `VX_HW_ITR_CTRL_BEGIN`/`END`;
  - an itr_req_t struct {wid, cause, vector}.
- One natural sub-module: VX_rr_arbiter (WARP_CNT requests plus pointer in, one-hot grant and index out, combinational).
- The CSR decode, register file and FSM stay in VX_hw_itr_ctrl.

Test Plan:
1. Reset mid-REQ: after irq and IE setup, hold itr_ready=0, pulse reset low -> itr_valid=0 immediately; IP=0 and in_handler=0 after release.
2. Write IE=0x05 for wid 2, VECTOR=0x8000_0103, irq wid2 src2 -> itr_valid high 2 cycles after the irq edge, itr_wid=2, cause=2, vector=0x8000_0100.
   - On ready: CAUSE[2] reads 2, IP[2] reads 0, in_handler[2]=1.
3. While in_handler[2]=1, irq wid2 src0 -> no itr_valid.
   - IP[2] reads 0x01.
   - RET write from wid 2 -> delivery of cause 0 follows 2 cycles later.
4. All 4 warps eligible with IE=0xFF via SWI=0x80, itr_ready always 1, RET issued after each grant -> grant order 0,1,2,3,0.
   - Deliveries spaced exactly 2 cycles apart.
5. Same-cycle irq set and IP write-1-clear of that bit -> IP bit reads 1.
   - Unmapped address BEGIN+7 read -> 0 on all NUM_LANES lanes.
